// File: rtl/phy_rx_pkg.sv
// Shared constants, state encoding and frame payload type for the serial receive stage.
package phy_rx_pkg;

    localparam logic [7:0]  COMMA           = 8'hBC;
    localparam logic [7:0]  MARK            = 8'h7C;
    localparam int unsigned FRAME_LEN       = 32;
    localparam int unsigned CNT_W           = $clog2(FRAME_LEN);
    localparam int unsigned GOOD_W          = 3;
    localparam int unsigned LOCK_FRAMES_DEF = 2;

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    typedef struct packed {
        logic [7:0] lane0;
        logic [7:0] lane1;
        logic [7:0] lane2;
        logic [7:0] lane3;
    } frame_t;

    // Reserved symbols never carry data.
    function automatic logic is_data(input logic [7:0] b);
        return (b != COMMA) && (b != MARK);
    endfunction

endpackage

// File: rtl/phy_rx_if.sv
// Serial input and recovered lane outputs of the receive stage.
interface phy_rx_if;
    logic       entrada_rx;
    logic [7:0] out0;
    logic [7:0] out1;
    logic [7:0] out2;
    logic [7:0] out3;
    logic       valid_out0;
    logic       valid_out1;
    logic       valid_out2;
    logic       valid_out3;
    logic       IDLE_out;
    logic       active;

    modport master (
        output entrada_rx,
        input  out0, out1, out2, out3,
        input  valid_out0, valid_out1, valid_out2, valid_out3,
        input  IDLE_out, active
    );

    modport slave (
        input  entrada_rx,
        output out0, out1, out2, out3,
        output valid_out0, valid_out1, valid_out2, valid_out3,
        output IDLE_out, active
    );
endinterface

// File: rtl/rx_sync_fsm.sv
// Byte/lane alignment: hunts for MARK, confirms frame spacing, then tracks byte boundaries.
module rx_sync_fsm
    import phy_rx_pkg::*;
#(
    parameter int unsigned LOCK_FRAMES = LOCK_FRAMES_DEF
) (
    input  logic       clk_32f,
    input  logic       rst,
    input  logic       entrada_rx,
    output logic [7:0] byte_c,
    output logic       byte_done_c,
    output logic [1:0] lane_c,
    output logic       lock_next_c,
    output logic       active
);

    logic [7:0]        sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [1:0]        state_q, state_d;
    logic              active_q, active_d;

    // Counter restarts after the MARK's last bit, so lane0 completes at the wrap.
    always_comb begin
        byte_c      = {sr_q[6:0], entrada_rx};
        sr_d        = byte_c;
        cnt_d       = cnt_q + CNT_W'(1);
        good_d      = good_q;
        state_d     = state_q;
        byte_done_c = (state_q != HUNT) && (cnt_q[2:0] == 3'd7);
        lane_c      = cnt_q[CNT_W-1 -: 2] + 2'd1;

        case (state_q)
            HUNT: begin
                if (byte_c == MARK) begin
                    cnt_d   = '0;
                    good_d  = GOOD_W'(1);
                    state_d = (LOCK_FRAMES <= 1) ? LOCKED : CHECK;
                end
            end
            CHECK: begin
                if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                    if (byte_c == MARK) begin
                        good_d = good_q + GOOD_W'(1);
                        if (good_d == GOOD_W'(LOCK_FRAMES)) state_d = LOCKED;
                    end else begin
                        state_d = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (byte_done_c && (lane_c != 2'd0) && (byte_c == MARK)) state_d = HUNT;
            end
            default: state_d = HUNT;
        endcase

        lock_next_c = (state_d == LOCKED);
        active_d    = lock_next_c;
    end

    always_ff @(posedge clk_32f or posedge rst) begin
        if (rst) begin
            sr_q     <= '0;
            cnt_q    <= '0;
            good_q   <= '0;
            state_q  <= HUNT;
            active_q <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            state_q  <= state_d;
            active_q <= active_d;
        end
    end

    assign active = active_q;

endmodule

// File: rtl/phy_rx.sv
// Serial receiver top: lane staging, frame-wide output load and valid/idle decode.
module phy_rx
    import phy_rx_pkg::*;
#(
    parameter int unsigned LOCK_FRAMES = LOCK_FRAMES_DEF
) (
    input  logic     clk_32f,
    input  logic     rst,
    phy_rx_if.slave  bus
);

    logic [7:0] byte_c;
    logic       byte_done_c;
    logic [1:0] lane_c;
    logic       lock_next_c;
    logic       fsm_active;

    logic [2:0][7:0] stage_q, stage_d;
    frame_t          out_q, out_d;
    frame_t          frame_c;
    logic [3:0]      valid_q, valid_d;
    logic            idle_q, idle_d;
    logic            upd_c;

    rx_sync_fsm #(.LOCK_FRAMES(LOCK_FRAMES)) u_sync (
        .clk_32f     (clk_32f),
        .rst         (rst),
        .entrada_rx  (bus.entrada_rx),
        .byte_c      (byte_c),
        .byte_done_c (byte_done_c),
        .lane_c      (lane_c),
        .lock_next_c (lock_next_c),
        .active      (fsm_active)
    );

    // Lanes 0..2 are staged; lane3 is taken straight from the completing byte.
    always_comb begin
        stage_d = stage_q;
        out_d   = out_q;
        valid_d = valid_q;
        idle_d  = idle_q;
        frame_c = {stage_q[0], stage_q[1], stage_q[2], byte_c};
        upd_c   = byte_done_c && (lane_c == 2'd3) && lock_next_c;

        if (byte_done_c) begin
            case (lane_c)
                2'd0:    stage_d[0] = byte_c;
                2'd1:    stage_d[1] = byte_c;
                2'd2:    stage_d[2] = byte_c;
                default: ;
            endcase
        end

        if (!lock_next_c) begin
            valid_d = '0;
            idle_d  = 1'b0;
        end else if (upd_c) begin
            out_d      = frame_c;
            valid_d[0] = is_data(frame_c.lane0);
            valid_d[1] = is_data(frame_c.lane1);
            valid_d[2] = is_data(frame_c.lane2);
            valid_d[3] = is_data(frame_c.lane3);
            idle_d     = (frame_c.lane0 == MARK);
        end
    end

    always_ff @(posedge clk_32f or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
            out_q   <= '0;
            valid_q <= '0;
            idle_q  <= 1'b0;
        end else begin
            stage_q <= stage_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            idle_q  <= idle_d;
        end
    end

    assign bus.out0       = out_q.lane0;
    assign bus.out1       = out_q.lane1;
    assign bus.out2       = out_q.lane2;
    assign bus.out3       = out_q.lane3;
    assign bus.valid_out0 = valid_q[0];
    assign bus.valid_out1 = valid_q[1];
    assign bus.valid_out2 = valid_q[2];
    assign bus.valid_out3 = valid_q[3];
    assign bus.IDLE_out   = idle_q;
    assign bus.active     = fsm_active;

endmodule
